// File: rtl/ctc_word_select.sv
// ctc_word_select: word counter, sync window, serial instruction capture, pointer P and ws decode for ARC
// Ports:
//   cph2_i       system clock, all state changes on posedge
//   rstb_i       asynchronous active-low reset
//   is_i         serial instruction, LSB first, sampled during sync
//   sync_o       high for bit times SYNC_START..SYNC_START+SYNC_LEN-1
//   ws_o         word select for the current word
//   bit_cnt_o    current bit time 0..WORD_BITS-1
//   digit_o      current digit, bit_cnt[5:2]
//   inst_o       instruction executing in the current word
//   inst_valid_o one-cycle pulse at bit_cnt==0 when inst updates
//   ptr_o        pointer register P
module ctc_word_select #(
  parameter int WORD_BITS  = 56,
  parameter int SYNC_START = 45,
  parameter int SYNC_LEN   = 10,
  parameter int P_INIT     = 3
) (
  input  logic                cph2_i,
  input  logic                rstb_i,
  input  logic                is_i,
  output logic                sync_o,
  output logic                ws_o,
  output logic [5:0]          bit_cnt_o,
  output logic [3:0]          digit_o,
  output logic [SYNC_LEN-1:0] inst_o,
  output logic                inst_valid_o,
  output logic [3:0]          ptr_o
);
  localparam logic [3:0] LAST = 4'(WORD_BITS / 4 - 1);
  logic [5:0]          bit_cnt_q, bit_cnt_d;
  logic [SYNC_LEN-1:0] sr_q, sr_d, inst_q, inst_d;
  logic                inst_valid_q, inst_valid_d;
  logic [3:0]          ptr_q, ptr_d, sh, digit;
  logic                wrap, sync, hit;
  always_comb begin
    wrap         = bit_cnt_q == 6'(WORD_BITS - 1);
    sync         = bit_cnt_q >= 6'(SYNC_START) && bit_cnt_q < 6'(SYNC_START + SYNC_LEN);
    sh           = 4'(bit_cnt_q - 6'(SYNC_START));
    digit        = bit_cnt_q[5:2];
    bit_cnt_d    = wrap ? 6'd0 : bit_cnt_q + 6'd1;
    // each window bit is written exactly once per word, so OR-ing into a cleared register suffices
    sr_d         = wrap ? '0 : sync ? sr_q | (SYNC_LEN'(is_i) << sh) : sr_q;
    inst_d       = wrap ? sr_q : inst_q;
    inst_valid_d = wrap;
    // pointer ops act on the freshly completed instruction at the word boundary
    ptr_d        = !wrap                   ? ptr_q :
                   sr_q[5:0] == 6'b001100 ? sr_q[9:6] :
                   sr_q[5:0] == 6'b011100 ? (ptr_q == 4'd0 ? LAST : ptr_q - 4'd1) :
                   sr_q[5:0] == 6'b111100 ? (ptr_q >= LAST ? 4'd0 : ptr_q + 4'd1) :
                   ptr_q;
    hit          = inst_q[4:2] == 3'd0 ? digit == ptr_q :
                   inst_q[4:2] == 3'd1 ? digit >= 4'd3 && digit <= 4'd12 :
                   inst_q[4:2] == 3'd2 ? digit <= 4'd2 :
                   inst_q[4:2] == 3'd3 ? 1'b1 :
                   inst_q[4:2] == 3'd4 ? digit <= ptr_q :
                   inst_q[4:2] == 3'd5 ? digit >= 4'd3 && digit <= LAST :
                   inst_q[4:2] == 3'd6 ? digit == 4'd2 :
                   digit == LAST;
  end
  always_ff @(posedge cph2_i or negedge rstb_i) begin
    if (!rstb_i) begin
      bit_cnt_q    <= '0;
      sr_q         <= '0;
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
      ptr_q        <= 4'(P_INIT);
    end else begin
      bit_cnt_q    <= bit_cnt_d;
      sr_q         <= sr_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      ptr_q        <= ptr_d;
    end
  end
  assign sync_o       = sync;
  assign ws_o         = inst_q[1:0] != 2'b10 || hit;
  assign bit_cnt_o    = bit_cnt_q;
  assign digit_o      = digit;
  assign inst_o       = inst_q;
  assign inst_valid_o = inst_valid_q;
  assign ptr_o        = ptr_q;
endmodule

// File: tb/tb_ctc_word_select.sv
// tb_ctc_word_select: randomized and directed check of ctc_word_select against a word-level model
module tb_ctc_word_select;
  logic       clk = 1'b0, rstb = 1'b0, is_b = 1'b0;
  logic       sync, ws, inst_valid;
  logic [5:0] bit_cnt;
  logic [3:0] digit, ptr;
  logic [9:0] inst;
  int total = 0, bad = 0;
  int seg = 1;
  logic [9:0] word_inst [0:63];
  int lit_cnt [1:14];
  int lit_ptr [9:14];
  int m_t = 0;
  logic [9:0] m_inst = '0;
  logic [3:0] m_ptr = 4'd3;
  int ws_cnt = 0, sync_cnt = 0, first_sync = -1;
  ctc_word_select dut (
    .cph2_i(clk), .rstb_i(rstb), .is_i(is_b), .sync_o(sync), .ws_o(ws),
    .bit_cnt_o(bit_cnt), .digit_o(digit), .inst_o(inst),
    .inst_valid_o(inst_valid), .ptr_o(ptr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s t=%0d got=%0d want=%0d", nm, m_t, act, exp);
    end
  endtask
  function automatic logic ref_ws(input logic [9:0] i, input int d, input int p);
    if (i[1:0] != 2'b10) return 1'b1;
    case (i[4:2])
      3'd0: return d == p;
      3'd1: return d >= 3 && d <= 12;
      3'd2: return d <= 2;
      3'd3: return 1'b1;
      3'd4: return d <= p;
      3'd5: return d >= 3 && d <= 13;
      3'd6: return d == 2;
      default: return d == 13;
    endcase
  endfunction
  function automatic logic [3:0] ref_ptr(input logic [9:0] s, input logic [3:0] p);
    case (s[5:0])
      6'b001100: return s[9:6];
      6'b011100: return p == 0 ? 4'd13 : p - 4'd1;
      6'b111100: return p >= 13 ? 4'd0 : p + 4'd1;
      default:   return p;
    endcase
  endfunction
  function automatic logic [9:0] rand_inst();
    int r;
    r = $urandom_range(0, 9);
    if (r < 4) return {5'($urandom), 3'($urandom), 2'b10};
    if (r < 7) begin
      r = $urandom_range(0, 2);
      return {4'($urandom), r == 0 ? 6'b001100 : r == 1 ? 6'b011100 : 6'b111100};
    end
    return 10'($urandom);
  endfunction
  always begin
    int b, w;
    @(posedge clk);
    #1;
    if (!rstb) begin
      m_t = 0; m_inst = '0; m_ptr = 4'd3; ws_cnt = 0; sync_cnt = 0; first_sync = -1;
    end else begin
      m_t++;
      if (m_t % 56 == 0) begin
        m_inst = word_inst[m_t / 56 - 1];
        m_ptr  = ref_ptr(word_inst[m_t / 56 - 1], m_ptr);
        ws_cnt = 0; sync_cnt = 0;
      end
    end
    b = m_t % 56;
    w = m_t / 56;
    chk("bit_cnt", bit_cnt, b);
    chk("digit", digit, b / 4);
    chk("sync", sync, b >= 45 && b <= 54);
    chk("ws", ws, ref_ws(m_inst, b / 4, m_ptr));
    chk("inst", inst, m_inst);
    chk("inst_valid", inst_valid, rstb && m_t > 0 && b == 0);
    chk("ptr", ptr, m_ptr);
    ws_cnt += ws;
    sync_cnt += sync;
    if (rstb && sync && first_sync < 0) first_sync = m_t;
    if (!rstb) begin
      chk("rst_bit_cnt", bit_cnt, 0);
      chk("rst_ptr", ptr, 3);
      chk("rst_ws", ws, 1);
    end else if (seg == 2) begin
      if (b == 55 && w >= 1) begin
        chk("sync_len", sync_cnt, 10);
        if (w <= 14) chk("ws_span", ws_cnt, lit_cnt[w]);
      end
      if (b == 0 && w >= 9 && w <= 14) chk("ptr_lit", ptr, lit_ptr[w]);
      if (b == 0 && w == 1) chk("t2_inst", inst, 'h3E2);
      if (w == 1 && (b == 11 || b == 12)) chk("t2_edge", ws, b == 12);
    end
  end
  always @(negedge clk) begin
    int b;
    b = m_t % 56;
    is_b = (rstb && b >= 45 && b <= 54) ? word_inst[m_t / 56][b - 45] : 1'($urandom);
  end
  initial begin
    lit_cnt = '{4, 40, 12, 56, 16, 44, 4, 4, 56, 56, 56, 56, 56, 56};
    lit_ptr = '{13, 0, 13, 15, 15, 15};
    foreach (word_inst[i]) word_inst[i] = rand_inst();
    repeat (2) @(negedge clk);
    rstb = 1'b1;
    repeat (3 * 56 + 48) @(posedge clk);
    #3 rstb = 1'b0;
    word_inst[0:13] = '{10'h3E2, 10'h3E6, 10'h3EA, 10'h3EE, 10'h3F2, 10'h3F6, 10'h3FA,
                        10'h3FE, 10'h34C, 10'h03C, 10'h01C, 10'h3CC, 10'h3F2, 10'h3A8};
    for (int i = 14; i < 64; i++) word_inst[i] = rand_inst();
    seg = 2;
    repeat (3) @(negedge clk);
    rstb = 1'b1;
    repeat (50 * 56) @(posedge clk);
    #3;
    chk("t1_first_sync", first_sync, 45);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
